mem_loader: RTL and testbench

Program loader and memory-port arbiter sitting directly upstream of the 256×8 data/program RAM of the multi-cycle processor. After reset it owns the RAM write port. It accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive addresses starting at 0. It then releases the RAM port to the processor core and raises `run`. A `start_load` pulse returns it to loading without a reset.

---
 rtl/mem_loader.sv | 134 +++++++++++++
 tb/tb_mem_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Program loader and RAM-port arbiter: streams a byte image into RAM from address 0,
// then hands the RAM port to the processor core and raises run.
module mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              start_load,
  input  logic [ADDR_W-1:0] cpu_A,
  input  logic [DATA_W-1:0] cpu_WD,
  input  logic              cpu_WE,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  output logic              run,
  output logic [ADDR_W:0]   load_count,
  output logic              full
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              run_q, run_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              full_q, full_d;

  logic xfer;
  logic at_end;

  // rst enters combinationally so in_ready is low for the whole reset window
  assign in_ready = (state_q == ST_LOAD) && rst;
  assign xfer     = in_valid && in_ready;
  assign at_end   = (ptr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = wr_en_q;
    run_d        = run_q;
    load_count_d = load_count_q;
    full_d       = full_q;
    case (state_q)
      ST_LOAD: begin
        wr_en_d = xfer;
        if (xfer) begin
          wr_addr_d    = ptr_q;
          wr_data_d    = in_data;
          load_count_d = load_count_q + 1'b1;
          if (in_last || at_end) begin
            state_d = ST_DRAIN;
            full_d  = at_end && !in_last;
          end else begin
            // pointer is held at the top address so it can never wrap
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        wr_en_d = 1'b0;
        state_d = ST_RUN;
        run_d   = 1'b1;
      end
      ST_RUN: begin
        if (start_load) begin
          state_d      = ST_LOAD;
          ptr_d        = '0;
          load_count_d = '0;
          full_d       = 1'b0;
          run_d        = 1'b0;
          wr_en_d      = 1'b0;
        end
      end
      default: begin
        state_d = ST_LOAD;
        wr_en_d = 1'b0;
        run_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LOAD;
      ptr_q        <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      run_q        <= 1'b0;
      load_count_q <= '0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      run_q        <= run_d;
      load_count_q <= load_count_d;
      full_q       <= full_d;
    end
  end

  // Core owns the RAM port only in RUN; its writes are dropped otherwise
  always_comb begin
    if (state_q == ST_RUN) begin
      mem_A  = cpu_A;
      mem_WD = cpu_WD;
      mem_WE = cpu_WE;
    end else begin
      mem_A  = wr_addr_q;
      mem_WD = wr_data_q;
      mem_WE = wr_en_q;
    end
  end

  assign run        = run_q;
  assign load_count = load_count_q;
  assign full       = full_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: drives the byte stream and core port, models the RAM
// the loader feeds, and checks outputs and RAM contents against hand-computed values.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       start_load;
  logic [7:0] cpu_A;
  logic [7:0] cpu_WD;
  logic       cpu_WE;
  logic [7:0] mem_A;
  logic [7:0] mem_WD;
  logic       mem_WE;
  logic       run;
  logic [8:0] load_count;
  logic       full;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram [256] = '{default: 8'hEE};

  mem_loader #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .start_load(start_load),
    .cpu_A(cpu_A), .cpu_WD(cpu_WD), .cpu_WE(cpu_WE),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
    .run(run), .load_count(load_count), .full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_WE) ram[mem_A] <= mem_WD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    start_load = 1'b0; cpu_A = 8'h00; cpu_WD = 8'h00; cpu_WE = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_A", 32'(mem_A), 32'd0);
    chk("rst_mem_WD", 32'(mem_WD), 32'd0);
    chk("rst_mem_WE", 32'(mem_WE), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst = 1'b1; #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back 3-byte image
    in_valid = 1'b1; in_data = 8'h11; tick();
    chk("b2b_we0", 32'(mem_WE), 32'd1);
    chk("b2b_a0", 32'(mem_A), 32'd0);
    chk("b2b_wd0", 32'(mem_WD), 32'h11);
    in_data = 8'h22; tick();
    chk("b2b_a1", 32'(mem_A), 32'd1);
    chk("b2b_wd1", 32'(mem_WD), 32'h22);
    in_data = 8'h33; in_last = 1'b1; tick();
    chk("b2b_a2", 32'(mem_A), 32'd2);
    chk("b2b_we2", 32'(mem_WE), 32'd1);
    chk("b2b_run_drain", 32'(run), 32'd0);
    chk("b2b_rdy_drain", 32'(in_ready), 32'd0);
    in_valid = 1'b0; in_last = 1'b0; tick();
    chk("b2b_run", 32'(run), 32'd1);
    chk("b2b_ram0", 32'(ram[0]), 32'h11);
    chk("b2b_ram1", 32'(ram[1]), 32'h22);
    chk("b2b_ram2", 32'(ram[2]), 32'h33);
    chk("b2b_count", 32'(load_count), 32'd3);
    chk("b2b_full", 32'(full), 32'd0);
    chk("run_we_idle", 32'(mem_WE), 32'd0);

    // Core write while running
    cpu_A = 8'h40; cpu_WD = 8'hAB; cpu_WE = 1'b1; #1;
    chk("pass_A", 32'(mem_A), 32'h40);
    chk("pass_WD", 32'(mem_WD), 32'hAB);
    tick();
    cpu_WE = 1'b0;
    chk("core_ram40", 32'(ram[8'h40]), 32'hAB);

    // Reload one byte; core writes during LOAD/DRAIN are dropped
    start_load = 1'b1; tick();
    start_load = 1'b0;
    chk("sl_run", 32'(run), 32'd0);
    chk("sl_rdy", 32'(in_ready), 32'd1);
    chk("sl_count", 32'(load_count), 32'd0);
    cpu_A = 8'h40; cpu_WD = 8'h77; cpu_WE = 1'b1; #1;
    chk("load_cpu_blocked", 32'(mem_WE), 32'd0);
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    cpu_WE = 1'b0;
    chk("rl_run", 32'(run), 32'd1);
    chk("rl_ram0", 32'(ram[0]), 32'h5A);
    chk("rl_ram1", 32'(ram[1]), 32'h22);
    chk("rl_ram2", 32'(ram[2]), 32'h33);
    chk("rl_ram40", 32'(ram[8'h40]), 32'hAB);
    chk("rl_count", 32'(load_count), 32'd1);

    // Valid with gaps: 1,0,0,1(last)
    start_load = 1'b1; tick();
    start_load = 1'b0;
    in_valid = 1'b1; in_data = 8'hA1; tick();
    chk("gap_we0", 32'(mem_WE), 32'd1);
    chk("gap_a0", 32'(mem_A), 32'd0);
    in_valid = 1'b0; tick();
    chk("gap_we_g1", 32'(mem_WE), 32'd0);
    tick();
    chk("gap_we_g2", 32'(mem_WE), 32'd0);
    in_valid = 1'b1; in_data = 8'hA2; in_last = 1'b1; tick();
    chk("gap_we1", 32'(mem_WE), 32'd1);
    chk("gap_a1", 32'(mem_A), 32'd1);
    in_valid = 1'b0; in_last = 1'b0; tick();
    chk("gap_run", 32'(run), 32'd1);
    chk("gap_count", 32'(load_count), 32'd2);
    chk("gap_ram0", 32'(ram[0]), 32'hA1);
    chk("gap_ram1", 32'(ram[1]), 32'hA2);
    chk("gap_ram2", 32'(ram[2]), 32'h33);

    // 256 bytes without in_last fill the RAM and set full
    start_load = 1'b1; tick();
    start_load = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'(i) ^ 8'hA5;
      if (i == 255) chk("full_rdy_last", 32'(in_ready), 32'd1);
      tick();
    end
    in_data = 8'hEE;
    chk("full_rdy_after", 32'(in_ready), 32'd0);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(load_count), 32'd256);
    tick();
    tick();
    in_valid = 1'b0;
    chk("full_run", 32'(run), 32'd1);
    chk("full_rdy_run", 32'(in_ready), 32'd0);
    chk("full_ram255", 32'(ram[255]), 32'h5A);
    chk("full_ram0", 32'(ram[0]), 32'hA5);
    chk("full_ram128", 32'(ram[128]), 32'h25);
    chk("full_count_run", 32'(load_count), 32'd256);
    chk("full_flag_run", 32'(full), 32'd1);

    // Reset after byte 3 of 5: pending write must not land
    start_load = 1'b1; tick();
    start_load = 1'b0;
    chk("rl2_full_clr", 32'(full), 32'd0);
    in_valid = 1'b1; in_data = 8'hC1; tick();
    in_data = 8'hC2; tick();
    in_data = 8'hC3; tick();
    rst = 1'b0; #1;
    chk("mr_we", 32'(mem_WE), 32'd0);
    chk("mr_count", 32'(load_count), 32'd0);
    chk("mr_rdy", 32'(in_ready), 32'd0);
    chk("mr_run", 32'(run), 32'd0);
    tick();
    rst = 1'b1; #1;
    chk("mr_rel_rdy", 32'(in_ready), 32'd1);
    in_data = 8'hD1; in_last = 1'b1; tick();
    chk("mr_new_a", 32'(mem_A), 32'd0);
    chk("mr_new_wd", 32'(mem_WD), 32'hD1);
    chk("mr_new_count", 32'(load_count), 32'd1);
    in_valid = 1'b0; in_last = 1'b0; tick();
    chk("mr_run_after", 32'(run), 32'd1);
    chk("mr_ram0", 32'(ram[0]), 32'hD1);
    chk("mr_ram1", 32'(ram[1]), 32'hC2);
    chk("mr_ram2", 32'(ram[2]), 32'hA7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
